// File: rtl/clock_pkg.sv
// Shared types and default timing constants
// for the clock set/run controller.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2
  } state_t;

  localparam int DIV_DEF   = 100_000_000;
  localparam int BLINK_DEF = 25_000_000;
  localparam int HOLD_DEF  = 100_000_000;
  localparam int RPT_DEF   = 25_000_000;

endpackage

// File: rtl/clock_set_ctrl_tick_gen.sv
// Modulo-N enable counter with synchronous clear;
// tick marks the enabled cycle that wraps to 0.
module tick_gen #(
  parameter int N = 2
) (
  input  logic ck,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt;

  assign tick = en && !clr && (cnt == LAST);

  always_ff @(posedge ck) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Run/set mode controller: seconds prescaler,
// set-mode blinking and increment auto-repeat.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int DIV        = DIV_DEF,
  parameter int BLINK_HALF = BLINK_DEF,
  parameter int HOLD_CYC   = HOLD_DEF,
  parameter int RPT_CYC    = RPT_DEF
) (
  input  logic       ck,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       carry_sec,
  input  logic       carry_min,
  output logic       up_sec,
  output logic       up_min,
  output logic       up_hour,
  output logic       blank_min,
  output logic       blank_hour,
  output logic [1:0] mode
);

  state_t state, state_nx;

  logic mode_q, inc_q, prime;
  logic mode_rise, inc_rise;
  logic in_run, in_set;
  logic pre_tick, blink_tick;
  logic hold_tick, rpt_tick;
  logic hold_done, hold_clr;
  logic toggle, inc_fire;
  logic inc_pulse_h, inc_pulse_m;

  // prime masks the first cycle after reset so
  // a button held through release gives no edge
  assign mode_rise = btn_mode & ~mode_q & ~prime;
  assign inc_rise  = btn_inc & ~inc_q & ~prime;

  assign in_run = (state == RUN);
  assign in_set = (state == SET_H)
                | (state == SET_M);

  assign hold_clr = ~in_set | ~btn_inc | mode_rise;
  assign inc_fire = in_set & ~mode_rise
                  & (inc_rise | hold_tick | rpt_tick);

  always_ff @(posedge ck) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      RUN:     if (mode_rise) state_nx = SET_H;
      SET_H:   if (mode_rise) state_nx = SET_M;
      SET_M:   if (mode_rise) state_nx = RUN;
      default: state_nx = RUN;
    endcase
  end

  tick_gen #(.N(DIV)) u_pre (
    .ck   (ck),
    .rst_n(rst_n),
    .en   (in_run),
    .clr  (~in_run | mode_rise),
    .tick (pre_tick)
  );

  tick_gen #(.N(BLINK_HALF)) u_blink (
    .ck   (ck),
    .rst_n(rst_n),
    .en   (in_set),
    .clr  (~in_set | mode_rise),
    .tick (blink_tick)
  );

  tick_gen #(.N(HOLD_CYC)) u_hold (
    .ck   (ck),
    .rst_n(rst_n),
    .en   (in_set & btn_inc & inc_q & ~hold_done),
    .clr  (hold_clr),
    .tick (hold_tick)
  );

  tick_gen #(.N(RPT_CYC)) u_rpt (
    .ck   (ck),
    .rst_n(rst_n),
    .en   (in_set & btn_inc & hold_done),
    .clr  (hold_clr),
    .tick (rpt_tick)
  );

  always_ff @(posedge ck) begin
    if (!rst_n) begin
      mode_q      <= 1'b0;
      inc_q       <= 1'b0;
      prime       <= 1'b1;
      up_sec      <= 1'b0;
      inc_pulse_h <= 1'b0;
      inc_pulse_m <= 1'b0;
      hold_done   <= 1'b0;
      toggle      <= 1'b0;
    end else begin
      mode_q      <= btn_mode;
      inc_q       <= btn_inc;
      prime       <= 1'b0;
      up_sec      <= pre_tick;
      inc_pulse_h <= inc_fire & (state == SET_H);
      inc_pulse_m <= inc_fire & (state == SET_M);
      if (hold_clr)       hold_done <= 1'b0;
      else if (hold_tick) hold_done <= 1'b1;
      if (~in_set | mode_rise) toggle <= 1'b0;
      else if (blink_tick)     toggle <= ~toggle;
    end
  end

  assign up_min     = (in_run & carry_sec) | inc_pulse_m;
  assign up_hour    = (in_run & carry_min) | inc_pulse_h;
  assign blank_hour = (state == SET_H) & toggle;
  assign blank_min  = (state == SET_M) & toggle;
  assign mode       = state;

endmodule

// File: doc/clock_set_ctrl.md
CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 Parameter DIV, default 100_000_000: clock cycles per 1 s tick; legal range >= 2.
REQ-002 Parameter BLINK_HALF, default 25_000_000: cycles per blink half-period; legal range >= 1.
REQ-003 Parameter HOLD_CYC, default 100_000_000: cycles btn_inc must be held before auto-repeat starts.
REQ-004 Parameter RPT_CYC, default 25_000_000: cycles between auto-repeat increments.
REQ-005 Clock and reset: one clock; reset is synchronous and active-low.
REQ-006 ck  in  1  clock; all state changes on its rising edge.
REQ-007 rst_n  in  1  synchronous active-low reset.
REQ-008 btn_mode  in  1  debounced mode button, level, high = pressed.
REQ-009 btn_inc  in  1  debounced increment button, level, high = pressed.
REQ-010 carry_sec  in  1  carry_to_hours of the seconds count60 instance.
REQ-011 carry_min  in  1  carry_to_hours of the minutes count60 instance.
REQ-012 up_sec  out  1  registered increment pulse to the seconds counter.
REQ-013 up_min  out  1  increment to the minutes counter.
REQ-014 up_hour  out  1  increment to the hours counter.
REQ-015 blank_min, blank_hour  out  1 each  display blanking, high = digits off.
REQ-016 mode  out  2  current state encoding: RUN=0, SET_H=1, SET_M=2.

Function
REQ-017 FSM states RUN, SET_H, SET_M; a rising edge of btn_mode moves RUN->SET_H->SET_M->RUN; no other transitions.
REQ-018 Rising edges are detected against a registered copy of each button; a level held high produces one edge only.
REQ-019 Prescaler counts 0..DIV-1 in RUN and wraps to 0; held at 0 in SET_H and SET_M.
REQ-020 up_sec is high for exactly one cycle, in the cycle after the prescaler reaches DIV-1 in RUN; it is never high outside RUN.
REQ-021 up_min = (RUN and carry_sec) or inc_pulse_m; up_hour = (RUN and carry_min) or inc_pulse_h; both are combinational, so the carry ripple completes in the same cycle as up_sec.
REQ-022 inc_pulse_h or inc_pulse_m is a registered one-cycle pulse, asserted on a btn_inc rising edge in SET_H or SET_M respectively.
REQ-023 Auto-repeat: if btn_inc is held HOLD_CYC cycles in a set state, one further pulse is issued, then one every RPT_CYC cycles until release; release clears the hold counter.
REQ-024 A btn_mode rising edge in the same cycle as a btn_inc rising edge, or during auto-repeat, changes state; the increment is suppressed, and the hold counter is cleared.
REQ-025 Blink toggle flips every BLINK_HALF cycles in set states; blank_hour = SET_H and toggle; blank_min = SET_M and toggle; both are 0 in RUN.
REQ-026 On entry to any state, the blink toggle and blink counter reset to 0, so digits are visible for the first half-period.
REQ-027 The prescaler resets on return to RUN, so the first up_sec occurs exactly DIV cycles later.

Reset
REQ-028 While rst_n is low at a rising edge of ck: state RUN, all counters 0, edge registers 0, all outputs 0.
REQ-029 A reset asserted mid-auto-repeat or mid-blink aborts the activity with no pulse in the following cycle.
REQ-030 A button held through reset release produces no edge until it is released and pressed again.

Structure
REQ-031 Shared package clock_pkg holds the state enum (RUN/SET_H/SET_M) and the default parameter constants.
REQ-032 One sub-module, tick_gen (parameterised modulo-N enable counter with synchronous clear), is instanced for the prescaler, blink and repeat timing.

Verification (bench parameters DIV=10, BLINK_HALF=4, HOLD_CYC=8, RPT_CYC=3)
REQ-033 Reset released, idle 35 cycles -> up_sec pulses at cycles 10, 20 and 30 after release; each pulse is 1 cycle wide.
REQ-034 Seconds counter driven to 59, carry_sec looped back -> up_min is high in the same cycle as the up_sec that wraps 59->00.
REQ-035 btn_mode pulse -> mode=1; blank_hour toggles every 4 cycles; up_sec stays low; btn_inc pulse -> exactly one up_hour pulse.
REQ-036 In SET_M, btn_inc held 20 cycles -> one pulse at the press, one 8 cycles later, then one every 3 cycles; none after release.
REQ-037 btn_mode and btn_inc rise in the same cycle in SET_H -> mode=2; no up_hour or up_min pulse.
REQ-038 rst_n low for 1 cycle during auto-repeat -> mode=0 and all outputs 0 on the next cycle; btn_inc still held -> no pulse.
